// File: rtl/mux_2x1_sync.sv
// mux_2x1_sync: 2:1 word selector with a combinational output Y and a
// registered copy Y_q. Defining MUX_2X1_SWITCH_CNT_EN builds a 16-bit
// saturating counter of select transitions on sw_cnt. Without that macro,
// sw_cnt is tied to zero.
module mux_2x1_sync #(
   parameter int WIDTH = 32
) (
   output logic [WIDTH-1:0] Y,
   input  logic             S,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] Y_q,
   output logic [15:0]      sw_cnt
);

   // Same-cycle select; rst deliberately has no influence here
   always_comb begin
      Y = S ? I1 : I0;
   end

   // Pipelined copy of the select result
   always_ff @(posedge clk) begin
      if (rst) Y_q <= '0;
      else     Y_q <= Y;
   end

`ifdef MUX_2X1_SWITCH_CNT_EN
   logic        s_prev_q;
   logic [15:0] sw_cnt_q;
   logic [15:0] sw_cnt_d;

   // Count select transitions, sticking at all-ones instead of wrapping
   always_comb begin
      sw_cnt_d = sw_cnt_q;
      if ((S != s_prev_q) && (sw_cnt_q != 16'hFFFF))
         sw_cnt_d = sw_cnt_q + 16'd1;
   end

   // Reset clears S history to 0 (not the incoming S) together with the count
   always_ff @(posedge clk) begin
      if (rst) begin
         s_prev_q <= 1'b0;
         sw_cnt_q <= 16'h0000;
      end else begin
         s_prev_q <= S;
         sw_cnt_q <= sw_cnt_d;
      end
   end

   assign sw_cnt = sw_cnt_q;
`else
   assign sw_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mux_2x1_sync.sv
// tb_mux_2x1_sync: directed bench for mux_2x1_sync. Expected Y_q and sw_cnt
// values are queued when stimulus is applied and compared after the edge.
module tb_mux_2x1_sync;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          S   = 1'b0;
   logic [W-1:0]  I0  = '0;
   logic [W-1:0]  I1  = '0;
   logic [W-1:0]  Y;
   logic [W-1:0]  Y_q;
   logic [15:0]   sw_cnt;

   int checks = 0;
   int errors = 0;

   // Scoreboard of {sw_cnt, Y_q} expected after the next edge
   logic [W+15:0] sb_q[$];

   // Reference state for the transition counter
   logic          m_prev = 1'b0;
   logic [15:0]   m_cnt  = 16'h0000;

   always #5 clk = ~clk;

   mux_2x1_sync #(.WIDTH(W)) dut (
      .Y(Y), .S(S), .I0(I0), .I1(I1), .clk(clk), .rst(rst),
      .Y_q(Y_q), .sw_cnt(sw_cnt)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply inputs away from the edge, check Y at once, then check registered
   // outputs one edge later against the queued expectation.
   task automatic step(input logic s, input logic [W-1:0] i0, input logic [W-1:0] i1,
                       input logic r, input logic chk_y);
      logic [W+15:0] e;
      @(negedge clk);
      S = s; I0 = i0; I1 = i1; rst = r;
      #1;
      if (chk_y) chk("Y_comb", Y, s ? i1 : i0);
`ifdef MUX_2X1_SWITCH_CNT_EN
      if (r) begin
         m_cnt  = 16'h0000;
         m_prev = 1'b0;
      end else begin
         if (s != m_prev && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         m_prev = s;
      end
`endif
      sb_q.push_back({m_cnt, (r ? {W{1'b0}} : (s ? i1 : i0))});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("Y_q", Y_q, e[W-1:0]);
      chk("sw_cnt", {16'h0, sw_cnt}, {16'h0, e[W+15:W]});
   endtask

   initial begin
      // Combinational select, no edge needed
      I0 = 32'h0000_0000; I1 = 32'hFFFF_FFFF; S = 1'b0;
      #1 chk("Y_s0", Y, 32'h0000_0000);
      S = 1'b1;
      #1 chk("Y_s1", Y, 32'hFFFF_FFFF);

      // Reset with S=1: Y_q cleared while Y still follows I1
      step(1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1);
      chk("Y_in_rst", Y, 32'hFFFF_FFFF);
      chk("sw_cnt_rst", {16'h0, sw_cnt}, 32'h0);
      // First capture after release
      step(1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
      chk("Y_q_release", Y_q, 32'hFFFF_FFFF);

      // Alternating select with distinct patterns
      for (int k = 0; k < 4; k++)
         step(k[0], 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b1);

      // Reset mid-operation wins over a capture
      step(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
      // Three transitions after reset
      step(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
      step(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
      step(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
      step(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
`ifdef MUX_2X1_SWITCH_CNT_EN
      chk("sw_cnt_3", {16'h0, sw_cnt}, 32'd3);
`else
      chk("sw_cnt_off", {16'h0, sw_cnt}, 32'd0);
`endif
      // Reset concurrent with a toggle clears the count
      step(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
      chk("sw_cnt_rst_toggle", {16'h0, sw_cnt}, 32'd0);

`ifdef MUX_2X1_SWITCH_CNT_EN
      // Drive past saturation; count must stick at all-ones
      for (int k = 0; k < 65540; k++)
         step(~S, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b0);
      chk("sw_cnt_sat", {16'h0, sw_cnt}, 32'h0000_FFFF);
      step(~S, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b1);
      chk("sw_cnt_hold", {16'h0, sw_cnt}, 32'h0000_FFFF);
`else
      for (int k = 0; k < 8; k++)
         step(~S, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b1);
      chk("sw_cnt_off_end", {16'h0, sw_cnt}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
